// File: rtl/maquina_pkg.sv
// Shared definitions for the coffee machine: state codes, drink codes,
// recipe masks and the step-ordering helper used by the dispense sequencer.
package maquina_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AGUA   = 3'd1,
        CAFE   = 3'd2,
        LECHE  = 3'd3,
        CHOCO  = 3'd4,
        AZUCAR = 3'd5,
        LISTO  = 3'd6
    } estado_t;

    typedef enum logic [2:0] {
        EXPRESO   = 3'd0,
        AMERICANO = 3'd1,
        LATTE     = 3'd2,
        MOCHA     = 3'd3,
        CHOCOLATE = 3'd4
    } bebida_t;

    localparam int N_BEBIDAS = 5;

    // Ingredient masks {agua, cafe, leche, choco}, indexed by drink code.
    localparam logic [3:0] RECETA [N_BEBIDAS] = '{
        4'b0100,    // expreso
        4'b1100,    // americano
        4'b0110,    // latte
        4'b0111,    // mocha
        4'b0011     // chocolate
    };

    function automatic logic sel_valida(input logic [2:0] sel);
        return sel <= 3'(N_BEBIDAS - 1);
    endfunction

    // First enabled step at or after 'desde' in the fixed order
    // AGUA..AZUCAR; LISTO when nothing is left to dispense.
    function automatic estado_t siguiente_paso(input logic [2:0] desde,
                                               input logic [3:0] mask,
                                               input logic       sugar);
        logic [4:0] habil;
        logic [4:0] resto;
        estado_t    r;
        // bit 0 = agua ... bit 4 = azucar
        habil = {sugar, mask[0], mask[1], mask[2], mask[3]};
        resto = habil & (5'b11111 << (desde - 3'd1));
        if (desde == 3'd0 || desde > 3'd5) begin
            resto = 5'b00000;
        end
        if (resto[0])      r = AGUA;
        else if (resto[1]) r = CAFE;
        else if (resto[2]) r = LECHE;
        else if (resto[3]) r = CHOCO;
        else if (resto[4]) r = AZUCAR;
        else               r = LISTO;
        return r;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Clock prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
// A synchronous clear restarts the count so each step starts on a fresh period.
module divisor_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    import maquina_pkg::*;

    localparam int             W      = $clog2(TICK_DIV + 1);
    localparam logic [W-1:0]   ULTIMO = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == ULTIMO);

    // Next count: clear has priority, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/secuenciador_bebida.sv
// Dispense sequencer: opens one ingredient valve at a time, in a fixed order
// and for a timed number of ticks, then holds bebida_lista until the cup is taken.
module secuenciador_bebida #(
    parameter int TICK_DIV = 50_000_000,
    parameter int T_AGUA   = 4,
    parameter int T_CAFE   = 3,
    parameter int T_LECHE  = 3,
    parameter int T_CHOCO  = 2,
    parameter int T_AZUCAR = 1
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sel,
    input  logic       azucar_req,
    input  logic       abort,
    input  logic       retirada,
    output logic       agua,
    output logic       cafe,
    output logic       leche,
    output logic       choco,
    output logic       azucar,
    output logic       busy,
    output logic       bebida_lista,
    output logic       err,
    output logic [2:0] paso
);
    import maquina_pkg::*;

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = maxi(maxi(maxi(T_AGUA, T_CAFE), maxi(T_LECHE, T_CHOCO)), T_AZUCAR);
    localparam int TW    = $clog2(T_MAX + 1);

    estado_t       estado_q, estado_d;
    logic [3:0]    mask_q, mask_d;
    logic          azucar_q, azucar_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic [4:0]    valvulas_q, valvulas_d;   // {agua, cafe, leche, choco, azucar}
    logic          busy_q, busy_d;
    logic          lista_q, lista_d;
    logic          err_q, err_d;

    logic          en_div;
    logic          clr;
    logic          tick;
    logic [TW-1:0] ultimo_tick;
    logic          fin_paso;

    // The prescaler only runs inside a dispensing step; any state change
    // restarts both the prescaler and the tick counter.
    assign en_div = (estado_q == AGUA) || (estado_q == CAFE) || (estado_q == LECHE) ||
                    (estado_q == CHOCO) || (estado_q == AZUCAR);
    assign clr    = (estado_d != estado_q);

    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor (
        .clk   (clk_50Mhz),
        .rst_n (rst),
        .en    (en_div),
        .clr   (clr),
        .tick  (tick)
    );

    // Index of the final tick of the current step.
    always_comb begin
        ultimo_tick = '0;
        case (estado_q)
            AGUA:    ultimo_tick = TW'(T_AGUA - 1);
            CAFE:    ultimo_tick = TW'(T_CAFE - 1);
            LECHE:   ultimo_tick = TW'(T_LECHE - 1);
            CHOCO:   ultimo_tick = TW'(T_CHOCO - 1);
            AZUCAR:  ultimo_tick = TW'(T_AZUCAR - 1);
            default: ultimo_tick = '0;
        endcase
    end

    assign fin_paso = tick && (ticks_q == ultimo_tick);

    // Tick counter within the current step.
    always_comb begin
        ticks_d = ticks_q;
        if (clr) begin
            ticks_d = '0;
        end else if (tick) begin
            ticks_d = ticks_q + TW'(1);
        end
    end

    // Next state, order latching and invalid-selection pulse.
    always_comb begin
        estado_d = estado_q;
        mask_d   = mask_q;
        azucar_d = azucar_q;
        err_d    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (start && !abort) begin
                    if (sel_valida(sel)) begin
                        mask_d   = RECETA[sel];
                        azucar_d = azucar_req;
                        estado_d = siguiente_paso(AGUA, RECETA[sel], azucar_req);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            AGUA, CAFE, LECHE, CHOCO, AZUCAR: begin
                if (abort) begin
                    estado_d = IDLE;
                end else if (fin_paso) begin
                    estado_d = siguiente_paso(estado_q + 3'd1, mask_q, azucar_q);
                end
            end
            LISTO: begin
                if (abort || retirada) begin
                    estado_d = IDLE;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Outputs registered from the next state, so valves change in step with the state.
    always_comb begin
        valvulas_d = 5'b00000;
        case (estado_d)
            AGUA:    valvulas_d = 5'b10000;
            CAFE:    valvulas_d = 5'b01000;
            LECHE:   valvulas_d = 5'b00100;
            CHOCO:   valvulas_d = 5'b00010;
            AZUCAR:  valvulas_d = 5'b00001;
            default: valvulas_d = 5'b00000;
        endcase
        busy_d  = (estado_d != IDLE);
        lista_d = (estado_d == LISTO);
    end

    // State and output registers; reset closes every valve immediately.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            estado_q   <= IDLE;
            mask_q     <= 4'b0000;
            azucar_q   <= 1'b0;
            ticks_q    <= '0;
            valvulas_q <= 5'b00000;
            busy_q     <= 1'b0;
            lista_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            mask_q     <= mask_d;
            azucar_q   <= azucar_d;
            ticks_q    <= ticks_d;
            valvulas_q <= valvulas_d;
            busy_q     <= busy_d;
            lista_q    <= lista_d;
            err_q      <= err_d;
        end
    end

    assign agua         = valvulas_q[4];
    assign cafe         = valvulas_q[3];
    assign leche        = valvulas_q[2];
    assign choco        = valvulas_q[1];
    assign azucar       = valvulas_q[0];
    assign busy         = busy_q;
    assign bebida_lista = lista_q;
    assign err          = err_q;
    assign paso         = estado_q;

endmodule

// File: tb/tb_secuenciador_bebida.sv
// Bench for the dispense sequencer with TICK_DIV=4 and every step 2 ticks (8 cycles).
module tb_secuenciador_bebida;

    localparam int STEP_CYC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sel;
    logic       azucar_req;
    logic       abort;
    logic       retirada;
    logic       agua, cafe, leche, choco, azucar;
    logic       busy, bebida_lista, err;
    logic [2:0] paso;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    secuenciador_bebida #(
        .TICK_DIV (4),
        .T_AGUA   (2),
        .T_CAFE   (2),
        .T_LECHE  (2),
        .T_CHOCO  (2),
        .T_AZUCAR (2)
    ) dut (
        .clk_50Mhz    (clk),
        .rst          (rst),
        .start        (start),
        .sel          (sel),
        .azucar_req   (azucar_req),
        .abort        (abort),
        .retirada     (retirada),
        .agua         (agua),
        .cafe         (cafe),
        .leche        (leche),
        .choco        (choco),
        .azucar       (azucar),
        .busy         (busy),
        .bebida_lista (bebida_lista),
        .err          (err),
        .paso         (paso)
    );

    // ---------------- reference model ----------------
    // Order = list of ingredients (0 agua .. 4 azucar) still to pour;
    // m_cur is the ingredient being poured, 5 means the drink is ready.
    logic [3:0] receta_tb [5] = '{4'b0100, 4'b1100, 4'b0110, 4'b0111, 4'b0011};
    bit m_act;
    int m_cur;
    int m_rest;
    bit m_err;
    int m_cola[$];

    task automatic modelo_reset();
        m_act = 0; m_cur = 0; m_rest = 0; m_err = 0;
        m_cola.delete();
    endtask

    task automatic modelo_flanco();
        m_err = 0;
        if (!rst) begin
            modelo_reset();
        end else if (!m_act) begin
            if (start && !abort) begin
                if (sel <= 3'd4) begin
                    m_cola.delete();
                    for (int k = 0; k < 4; k++)
                        if (receta_tb[sel][3-k]) m_cola.push_back(k);
                    if (azucar_req) m_cola.push_back(4);
                    m_cur  = m_cola.pop_front();
                    m_rest = STEP_CYC;
                    m_act  = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (abort) begin
            m_act = 0;
        end else if (m_cur == 5) begin
            if (retirada) m_act = 0;
        end else begin
            m_rest--;
            if (m_rest == 0) begin
                if (m_cola.size() == 0) m_cur = 5;
                else begin
                    m_cur  = m_cola.pop_front();
                    m_rest = STEP_CYC;
                end
            end
        end
    endtask

    // {agua,cafe,leche,choco,azucar,busy,bebida_lista,err,paso}
    function automatic logic [10:0] esperado();
        logic [4:0] v = 5'b0;
        logic       b = 1'b0;
        logic       l = 1'b0;
        logic [2:0] p = 3'd0;
        if (m_act) begin
            b = 1'b1;
            if (m_cur == 5) begin
                l = 1'b1;
                p = 3'd6;
            end else begin
                v[4-m_cur] = 1'b1;
                p = 3'(m_cur + 1);
            end
        end
        return {v, b, l, m_err, p};
    endfunction

    function automatic logic [10:0] salidas();
        return {agua, cafe, leche, choco, azucar, busy, bebida_lista, err, paso};
    endfunction

    task automatic conducir(input logic s, input logic [2:0] sl, input logic az,
                            input logic ab, input logic rt);
        start = s; sel = sl; azucar_req = az; abort = ab; retirada = rt;
    endtask

    // One clock edge; model follows the same sampled inputs; return 1 time unit later.
    task automatic reloj();
        @(posedge clk);
        modelo_flanco();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        conducir(0, 3'd0, 0, 0, 0);
        #1 rst = 1'b0;
        modelo_reset();
        reloj();
        reloj();
        checks++;
        if (salidas() !== 11'd0) begin
            errors++;
            $display("FAIL reset obs=%b exp=%b", salidas(), 11'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        reloj();
        checks++;
        if (salidas() !== esperado()) begin
            errors++;
            $display("FAIL reset_release obs=%b exp=%b", salidas(), esperado());
        end
    endtask

    task automatic test_expreso();
        int n_cafe = 0;
        int c_lista = -1;
        conducir(1, 3'd0, 0, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            reloj();
            conducir(0, 3'd0, 0, 0, 0);
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL expreso ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
            if (cafe) n_cafe++;
            if (bebida_lista && c_lista < 0) c_lista = c;
        end
        checks++;
        if (n_cafe != 8) begin
            errors++;
            $display("FAIL expreso_cafe_ciclos obs=%0d exp=8", n_cafe);
        end
        checks++;
        if (c_lista != 9) begin
            errors++;
            $display("FAIL expreso_ciclo_lista obs=%0d exp=9", c_lista);
        end
        conducir(0, 3'd0, 0, 0, 1);
        reloj();
        conducir(0, 3'd0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || bebida_lista !== 1'b0 || paso !== 3'd0) begin
            errors++;
            $display("FAIL expreso_retirada obs=busy%b lista%b paso%0d exp=busy0 lista0 paso0",
                     busy, bebida_lista, paso);
        end
    endtask

    task automatic test_mocha_azucar();
        int cnt [5] = '{0, 0, 0, 0, 0};
        int pasos[$];
        int pasos_exp[$] = '{2, 3, 4, 5, 6};
        int multi = 0;
        logic [2:0] ult = 3'd0;
        conducir(1, 3'd3, 1, 0, 0);
        for (int c = 1; c <= 36; c++) begin
            reloj();
            conducir(0, 3'd0, 0, 0, 0);
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL mocha ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
            if ($countones({agua, cafe, leche, choco, azucar}) > 1) multi++;
            if (c <= 32 && $countones({agua, cafe, leche, choco, azucar}) != 1) multi++;
            cnt[0] += int'(agua); cnt[1] += int'(cafe); cnt[2] += int'(leche);
            cnt[3] += int'(choco); cnt[4] += int'(azucar);
            if (busy && paso != ult) pasos.push_back(int'(paso));
            ult = paso;
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL mocha_una_valvula obs=%0d ciclos_malos exp=0", multi);
        end
        checks++;
        if (cnt[0] != 0 || cnt[1] != 8 || cnt[2] != 8 || cnt[3] != 8 || cnt[4] != 8) begin
            errors++;
            $display("FAIL mocha_duraciones obs=%0d,%0d,%0d,%0d,%0d exp=0,8,8,8,8",
                     cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]);
        end
        checks++;
        if (pasos != pasos_exp) begin
            errors++;
            $display("FAIL mocha_pasos obs=%p exp=%p", pasos, pasos_exp);
        end
        conducir(0, 3'd0, 0, 0, 1);
        reloj();
        conducir(0, 3'd0, 0, 0, 0);
        checks++;
        if (salidas() !== esperado()) begin
            errors++;
            $display("FAIL mocha_retirada obs=%b exp=%b", salidas(), esperado());
        end
    endtask

    task automatic test_sel_invalida();
        int n_err = 0;
        int n_activo = 0;
        conducir(1, 3'd6, 1, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            reloj();
            conducir(0, 3'd6, 0, 0, 0);
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL sel_invalida ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
            n_err += int'(err);
            if (busy || agua || cafe || leche || choco || azucar) n_activo++;
        end
        checks++;
        if (n_err != 1 || n_activo != 0) begin
            errors++;
            $display("FAIL sel_invalida_pulso obs=err%0d activo%0d exp=err1 activo0", n_err, n_activo);
        end
    endtask

    task automatic test_abort();
        int n_lista = 0;
        conducir(1, 3'd1, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            reloj();
            conducir(0, 3'd0, 0, (c == 4) ? 1'b1 : 1'b0, 0);
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL abort ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
        end
        conducir(0, 3'd0, 0, 1, 0);
        reloj();
        conducir(0, 3'd0, 0, 0, 0);
        checks++;
        if (agua !== 1'b0 || busy !== 1'b0 || paso !== 3'd0) begin
            errors++;
            $display("FAIL abort_cierre obs=agua%b busy%b paso%0d exp=agua0 busy0 paso0",
                     agua, busy, paso);
        end
        for (int c = 0; c < 20; c++) begin
            reloj();
            if (bebida_lista) n_lista++;
        end
        checks++;
        if (n_lista != 0) begin
            errors++;
            $display("FAIL abort_sin_lista obs=%0d exp=0", n_lista);
        end
    endtask

    task automatic test_start_ignorado();
        int n_cafe = 0, n_leche = 0, n_otros = 0;
        conducir(1, 3'd2, 0, 0, 0);
        for (int c = 1; c <= 18; c++) begin
            reloj();
            if (c == 2) conducir(1, 3'd0, 1, 0, 0);
            else        conducir(0, 3'd0, 0, 0, 0);
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL start_ignorado ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
            n_cafe  += int'(cafe);
            n_leche += int'(leche);
            n_otros += int'(agua) + int'(choco) + int'(azucar);
        end
        checks++;
        if (n_cafe != 8 || n_leche != 8 || n_otros != 0) begin
            errors++;
            $display("FAIL start_ignorado_receta obs=cafe%0d leche%0d otros%0d exp=cafe8 leche8 otros0",
                     n_cafe, n_leche, n_otros);
        end
        conducir(0, 3'd0, 0, 0, 1);
        reloj();
        conducir(0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_reset_async();
        conducir(1, 3'd4, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            reloj();
            conducir(0, 3'd0, 0, 0, 0);
        end
        checks++;
        if (leche !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_previo obs=leche%b exp=leche1", leche);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (salidas() !== 11'd0) begin
            errors++;
            $display("FAIL reset_async obs=%b exp=%b", salidas(), 11'd0);
        end
        modelo_reset();
        reloj();
        reloj();
        #2 rst = 1'b1;
        reloj();
        conducir(1, 3'd0, 0, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            reloj();
            conducir(0, 3'd0, 0, 0, (c == 11) ? 1'b1 : 1'b0);
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL reset_async_nuevo ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 3000; c++) begin
            conducir(($urandom_range(0, 5) == 0),
                     3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 7) == 0));
            reloj();
            checks++;
            if (salidas() !== esperado()) begin
                errors++;
                $display("FAIL aleatorio ciclo %0d obs=%b exp=%b", c, salidas(), esperado());
            end
        end
    endtask

    initial begin
        modelo_reset();
        test_reset();
        test_expreso();
        test_mocha_azucar();
        test_sel_invalida();
        test_abort();
        test_start_ignorado();
        test_reset_async();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
